ltc2600_cmd_queue: RTL and testbench

- Upstream command sequencer for the LTC2600 serial writer.
- Accepts DAC commands from the register/IPIF side via valid/ready, screens illegal codes, and buffers them in a FIFO.
- Issues one writer transaction at a time: a single-cycle send_new_cmd pulse, with command/address/data held stable until write_complete.
- Keeps a completed-write counter and sticky error flags for software.

---
 rtl/ltc2600_cmd_queue.sv | 159 +++++++++++++++
 tb/tb_ltc2600_cmd_queue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2600_cmd_queue.sv
// Command queue and launch sequencer feeding the LTC2600 serial writer.
// Optional writer watchdog is enabled by defining LTC2600_CMDQ_TIMEOUT_EN.
module ltc2600_cmd_queue #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [3:0]              push_cmd,
  input  logic [3:0]              push_addr,
  input  logic [DATA_WIDTH-1:0]   push_data,
  output logic                    send_new_cmd,
  output logic [3:0]              command,
  output logic [3:0]              address,
  output logic [DATA_WIDTH-1:0]   data,
  input  logic                    write_complete,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic [15:0]             done_count,
  output logic                    err_illegal,
  output logic                    err_timeout,
  input  logic                    clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 8 + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_e;

  state_e                  state_q, state_d;
  logic [EW-1:0]           mem [DEPTH];
  logic [AW-1:0]           wrPtr_q, rdPtr_q;
  logic [LW-1:0]           count_q, count_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [3:0]              addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    send_q, send_d;
  logic [15:0]             doneCnt_q, doneCnt_d;
  logic                    errIll_q, errIll_d;
  logic                    pushFire, cmdLegal, storeEn, popEn, timeoutHit;
  logic [EW-1:0]           headEntry;

  assign push_ready   = (count_q != LW'(DEPTH));
  assign pushFire     = push_valid && push_ready;
  assign cmdLegal     = (push_cmd <= 4'h4) || (push_cmd == 4'hF);
  assign storeEn      = pushFire && cmdLegal;
  assign popEn        = (state_q == IDLE) && (count_q != '0);
  assign headEntry    = mem[rdPtr_q];

  assign level        = count_q;
  assign busy         = (state_q != IDLE) || (count_q != '0);
  assign send_new_cmd = send_q;
  assign command      = cmd_q;
  assign address      = addr_q;
  assign data         = data_q;
  assign done_count   = doneCnt_q;
  assign err_illegal  = errIll_q;

`ifdef LTC2600_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          errTo_q, errTo_d;

  assign timeoutHit  = (state_q == WAIT_DONE) && !write_complete &&
                       (toCnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign toCnt_d     = ((state_q == WAIT_DONE) && !write_complete && !timeoutHit) ?
                       toCnt_q + TW'(1) : '0;
  assign errTo_d     = timeoutHit ? 1'b1 : (clr_err ? 1'b0 : errTo_q);
  assign err_timeout = errTo_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      toCnt_q <= '0;
      errTo_q <= 1'b0;
    end else begin
      toCnt_q <= toCnt_d;
      errTo_q <= errTo_d;
    end
  end
`else
  assign timeoutHit  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // A same-cycle pop never frees space for this cycle's push: ready looks only at count_q.
  assign count_d  = count_q + LW'(storeEn) - LW'(popEn);
  assign errIll_d = (pushFire && !cmdLegal) ? 1'b1 : (clr_err ? 1'b0 : errIll_q);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    send_d    = 1'b0;
    doneCnt_d = doneCnt_q;
    case (state_q)
      IDLE: begin
        if (popEn && (headEntry[EW-1 -: 4] != 4'hF)) begin
          cmd_d   = headEntry[EW-1 -: 4];
          addr_d  = headEntry[DATA_WIDTH +: 4];
          data_d  = headEntry[DATA_WIDTH-1:0];
          state_d = LAUNCH;
        end
      end
      // The launch pulse is registered, so it is visible during the first WAIT_DONE cycle.
      LAUNCH: begin
        send_d  = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (write_complete) begin
          doneCnt_d = doneCnt_q + 16'd1;
          state_d   = IDLE;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (storeEn) begin
      mem[wrPtr_q] <= {push_cmd, push_addr, push_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      send_q    <= 1'b0;
      doneCnt_q <= '0;
      errIll_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= storeEn ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_q   <= popEn ? rdPtr_q + AW'(1) : rdPtr_q;
      count_q   <= count_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      send_q    <= send_d;
      doneCnt_q <= doneCnt_d;
      errIll_q  <= errIll_d;
    end
  end

endmodule

// File: tb/tb_ltc2600_cmd_queue.sv
// Scoreboard bench for ltc2600_cmd_queue with a behavioural writer and random traffic.
// Honours LTC2600_CMDQ_TIMEOUT_EN when checking the watchdog behaviour.
module tb_ltc2600_cmd_queue;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [3:0]    c;
    logic [3:0]    a;
    logic [DW-1:0] d;
  } entry_t;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    push_valid;
  logic                    push_ready;
  logic [3:0]              push_cmd;
  logic [3:0]              push_addr;
  logic [DW-1:0]           push_data;
  logic                    send_new_cmd;
  logic [3:0]              command;
  logic [3:0]              address;
  logic [DW-1:0]           data;
  logic                    write_complete;
  logic [$clog2(DEPTH):0]  level;
  logic                    busy;
  logic [15:0]             done_count;
  logic                    err_illegal;
  logic                    err_timeout;
  logic                    clr_err;

  int     total = 0;
  int     bad = 0;
  entry_t sbq[$];
  int     pulseCount = 0;
  int     expDone = 0;
  bit     expIllegal = 0;
  bit     stallWriter = 0;
  bit     withhold = 0;
  int     latMin = 26;
  int     latMax = 26;
  bit     wBusy = 0;

  ltc2600_cmd_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rstn(rstn),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_cmd(push_cmd), .push_addr(push_addr), .push_data(push_data),
    .send_new_cmd(send_new_cmd), .command(command), .address(address), .data(data),
    .write_complete(write_complete), .level(level), .busy(busy),
    .done_count(done_count), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .clr_err(clr_err)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Offer one command; the model records what the writer should later see.
  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] a,
                               input logic [DW-1:0] d, input int budget);
    int waited = 0;
    @(negedge clk);
    push_valid = 1'b1;
    push_cmd   = c;
    push_addr  = a;
    push_data  = d;
    while (!push_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!push_ready) begin
      failNow("pushAccept");
      push_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (c <= 4'h4) sbq.push_back('{c: c, a: a, d: d});
    else if (c != 4'hF) expIllegal = 1'b1;
    #1 push_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !wBusy && sbq.size() == 0) break;
    end
    if (i == budget) failNow("drain");
  endtask

  task automatic waitPulses(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pulseCount >= target) break;
    end
    if (i == budget) failNow("pulseWait");
  endtask

  // Monitor: every launch pulse must match the oldest expected legal command.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rstn && send_new_cmd) begin
        pulseCount++;
        if (sbq.size() == 0) begin
          failNow("unexpectedLaunch");
        end else begin
          e = sbq.pop_front();
          checkOutput("launch", {8'h0, command, address, data}, {8'h0, e});
        end
      end
    end
  end

  // Writer model: latches the launch, checks hold/gap rules, answers after a latency.
  initial begin
    int     wLeft = 0;
    bit     justDone = 0;
    entry_t snap = '0;
    write_complete = 1'b0;
    forever begin
      @(negedge clk);
      write_complete = 1'b0;
      if (!rstn) begin
        wBusy    = 0;
        justDone = 0;
        continue;
      end
      if (justDone && send_new_cmd) failNow("gapAfterComplete");
      justDone = 0;
      if (wBusy) begin
        if (send_new_cmd) begin
          if (withhold) begin
            snap  = {command, address, data};
            wLeft = $urandom_range(latMax, latMin);
          end else begin
            failNow("overlapPulse");
          end
        end else begin
          if (!withhold) checkOutput("holdStable", {8'h0, command, address, data}, {8'h0, snap});
          if (!stallWriter && !withhold) wLeft--;
          if (wLeft <= 0) begin
            write_complete = 1'b1;
            wBusy    = 0;
            justDone = 1;
            expDone++;
          end
        end
      end else if (send_new_cmd) begin
        wBusy = 1;
        snap  = {command, address, data};
        wLeft = $urandom_range(latMax, latMin);
      end
    end
  end

  initial begin
    int p0;
    int r;
    logic [3:0] c;
    rstn = 1'b0;
    push_valid = 1'b0;
    push_cmd = '0;
    push_addr = '0;
    push_data = '0;
    clr_err = 1'b0;
    #35;
    checkOutput("rstReady", push_ready, 1);
    checkOutput("rstSend", send_new_cmd, 0);
    checkOutput("rstLevel", level, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done_count, 0);
    checkOutput("rstErrs", {err_illegal, err_timeout}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single write and launch latency
    applyStimulus(4'h3, 4'h2, 16'hABCD, 10);
    checkOutput("latEdgeN", send_new_cmd, 0);
    @(posedge clk); #1;
    checkOutput("latEdgeN1", send_new_cmd, 0);
    @(posedge clk); #1;
    checkOutput("latEdgeN2", send_new_cmd, 1);
    waitDrain(200);
    checkOutput("doneSingle", done_count, 1);

    // Burst of three against a 26-cycle writer
    p0 = pulseCount;
    applyStimulus(4'h0, 4'h1, 16'h1111, 10);
    applyStimulus(4'h1, 4'h5, 16'h2222, 10);
    applyStimulus(4'h2, 4'h9, 16'h3333, 10);
    waitDrain(500);
    checkOutput("burstPulses", pulseCount - p0, 3);
    checkOutput("burstDone", done_count, 4);

    // Backpressure: writer stalled while DEPTH+2 commands are offered
    latMin = 8;
    latMax = 8;
    stallWriter = 1;
    p0 = pulseCount;
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++)
          applyStimulus(4'($urandom_range(4, 0)), 4'(i), 16'($urandom), 300);
      end
      begin
        repeat (30) @(negedge clk);
        checkOutput("fullLevel", level, DEPTH);
        checkOutput("fullReady", push_ready, 0);
        stallWriter = 0;
      end
    join
    waitDrain(1000);
    checkOutput("fullPulses", pulseCount - p0, DEPTH + 2);
    checkOutput("fullDone", done_count, expDone);

    // Illegal code, NOP, then a real write
    latMin = 26;
    latMax = 26;
    p0 = pulseCount;
    applyStimulus(4'h7, 4'h0, 16'h0, 10);
    applyStimulus(4'hF, 4'h0, 16'h0, 10);
    applyStimulus(4'h0, 4'h1, 16'h1234, 10);
    checkOutput("nopLevel", level, 1);
    checkOutput("illSet", err_illegal, 1);
    waitDrain(200);
    checkOutput("nopPulses", pulseCount - p0, 1);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    expIllegal = 0;
    checkOutput("illClear", err_illegal, 0);
    clr_err = 1'b1;
    applyStimulus(4'h9, 4'h0, 16'h0, 10);
    clr_err = 1'b0;
    checkOutput("illSetWins", err_illegal, 1);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    expIllegal = 0;

    // Writer that never answers
    withhold = 1;
    p0 = pulseCount;
    applyStimulus(4'h4, 4'h3, 16'hBEEF, 10);
    applyStimulus(4'h1, 4'h4, 16'hCAFE, 10);
`ifdef LTC2600_CMDQ_TIMEOUT_EN
    waitPulses(p0 + 2, 200);
    withhold = 0;
    checkOutput("toErr", err_timeout, 1);
    checkOutput("toDone", done_count, expDone);
    waitDrain(200);
    checkOutput("toSticky", err_timeout, 1);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    checkOutput("toClear", err_timeout, 0);
`else
    repeat (1000) @(negedge clk);
    checkOutput("noToPulses", pulseCount - p0, 1);
    checkOutput("noToBusy", busy, 1);
    checkOutput("noToErr", err_timeout, 0);
    checkOutput("noToDone", done_count, expDone);
    withhold = 0;
    waitDrain(200);
    checkOutput("noToPulses2", pulseCount - p0, 2);
`endif

    // Asynchronous reset in the middle of a transaction
    latMin = 8;
    latMax = 8;
    stallWriter = 1;
    for (int i = 0; i < 5; i++) applyStimulus(4'h2, 4'(i), 16'(i * 3), 10);
    repeat (3) @(negedge clk);
    checkOutput("preRstLevel", level, 4);
    #3 rstn = 1'b0;
    #1;
    checkOutput("midRstLevel", level, 0);
    checkOutput("midRstSend", send_new_cmd, 0);
    checkOutput("midRstDone", done_count, 0);
    checkOutput("midRstReady", push_ready, 1);
    checkOutput("midRstBusy", busy, 0);
    sbq.delete();
    expDone = 0;
    expIllegal = 0;
    stallWriter = 0;
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic with variable writer latency
    latMin = 1;
    latMax = 30;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(99, 0);
      if (r < 70) c = 4'($urandom_range(4, 0));
      else if (r < 85) c = 4'hF;
      else c = 4'($urandom_range(14, 5));
      applyStimulus(c, 4'($urandom), 16'($urandom), 2000);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    waitDrain(5000);
    checkOutput("rndDone", done_count, expDone);
    checkOutput("rndIllegal", err_illegal, expIllegal);
    checkOutput("rndLevel", level, 0);
    checkOutput("rndSbEmpty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
